// File: rtl/id_ex_control_unit.sv
// rtl/id_ex_control_unit.sv - main-control decoder and ID/EX control pipeline register
module id_ex_control_unit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             id_valid,
    input  logic             stall,
    input  logic             flush,
    output logic [1:0]       ALUop,
    output logic [5:0]       func,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             ALUSrc,
    output logic             RegDst,
    output logic             BranchEq,
    output logic             BranchNe,
    output logic             Jump,
    output logic             ex_valid,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic {S_BOOT, S_RUN} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_legal;
    logic [1:0]         w_alu_op;
    logic [8:0]         w_ctrl;
    logic               w_bubble;
    logic               w_illegal;
    logic [1:0]         r_alu_op;
    logic [5:0]         r_func;
    logic [8:0]         r_ctrl;
    logic               r_ex_valid;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_BOOT;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_BOOT:  w_next_state = S_RUN;
            S_RUN:   w_next_state = S_RUN;
            default: w_next_state = S_BOOT;
        endcase
    end

    // w_ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, BranchEq, BranchNe, Jump}
    always_comb begin
        w_legal  = 1'b1;
        w_alu_op = 2'b00;
        w_ctrl   = 9'b0;
        case (opcode)
            6'b000000: begin
                w_alu_op = 2'b10;
                w_ctrl   = 9'b100001000;
                if (funct != 6'b100000 && funct != 6'b100010 && funct != 6'b101010)
                    w_legal = 1'b0;
            end
            6'b100011: w_ctrl = 9'b110110000;
            6'b101011: w_ctrl = 9'b001010000;
            6'b001000: w_ctrl = 9'b100010000;
            6'b001010: begin w_alu_op = 2'b11; w_ctrl = 9'b100010000; end
            6'b000100: begin w_alu_op = 2'b01; w_ctrl = 9'b000000100; end
            6'b000101: begin w_alu_op = 2'b01; w_ctrl = 9'b000000010; end
            6'b000010: w_ctrl = 9'b000000001;
            default:   w_legal = 1'b0;
        endcase
    end

    // Illegal is only judged for an instruction that would actually enter EX.
    assign w_bubble  = (r_state == S_BOOT) | flush | stall | ~id_valid | ~w_legal;
    assign w_illegal = (r_state == S_RUN) & ~flush & ~stall & id_valid & ~w_legal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alu_op   <= 2'b00;
            r_func     <= 6'b0;
            r_ctrl     <= 9'b0;
            r_ex_valid <= 1'b0;
            r_illegal  <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_illegal <= w_illegal;
            if (w_bubble) begin
                r_alu_op   <= 2'b00;
                r_func     <= 6'b0;
                r_ctrl     <= 9'b0;
                r_ex_valid <= 1'b0;
            end else begin
                r_alu_op   <= w_alu_op;
                r_func     <= (opcode == 6'b000000) ? funct : 6'b0;
                r_ctrl     <= w_ctrl;
                r_ex_valid <= 1'b1;
            end
            if (w_illegal && r_cnt != {CNT_W{1'b1}})
                r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign ALUop       = r_alu_op;
    assign func        = r_func;
    assign RegWrite    = r_ctrl[8];
    assign MemRead     = r_ctrl[7];
    assign MemWrite    = r_ctrl[6];
    assign MemtoReg    = r_ctrl[5];
    assign ALUSrc      = r_ctrl[4];
    assign RegDst      = r_ctrl[3];
    assign BranchEq    = r_ctrl[2];
    assign BranchNe    = r_ctrl[1];
    assign Jump        = r_ctrl[0];
    assign ex_valid    = r_ex_valid;
    assign illegal     = r_illegal;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_id_ex_control_unit.sv
// tb/tb_id_ex_control_unit.sv - scoreboard bench for id_ex_control_unit
module tb_id_ex_control_unit;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_ADDI = 6'b001000, OP_SLTI = 6'b001010, OP_BEQ = 6'b000100,
                           OP_BNE = 6'b000101, OP_J = 6'b000010, OP_BAD = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLT = 6'b101010, F_AND = 6'b100100;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       id_valid = 1'b0, stall = 1'b0, flush = 1'b0;

    logic [1:0] ALUop;
    logic [5:0] func;
    logic RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, BranchEq, BranchNe, Jump;
    logic ex_valid, illegal;
    logic [7:0] illegal_cnt;

    logic [1:0] d2_ALUop;
    logic [5:0] d2_func;
    logic d2_RegWrite, d2_MemRead, d2_MemWrite, d2_MemtoReg, d2_ALUSrc, d2_RegDst;
    logic d2_BranchEq, d2_BranchNe, d2_Jump, d2_ex_valid, d2_illegal;
    logic [1:0] d2_cnt;

    id_ex_control_unit #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .id_valid(id_valid),
        .stall(stall), .flush(flush), .ALUop(ALUop), .func(func),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .ALUSrc(ALUSrc), .RegDst(RegDst), .BranchEq(BranchEq), .BranchNe(BranchNe),
        .Jump(Jump), .ex_valid(ex_valid), .illegal(illegal), .illegal_cnt(illegal_cnt)
    );

    id_ex_control_unit #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .id_valid(id_valid),
        .stall(stall), .flush(flush), .ALUop(d2_ALUop), .func(d2_func),
        .RegWrite(d2_RegWrite), .MemRead(d2_MemRead), .MemWrite(d2_MemWrite),
        .MemtoReg(d2_MemtoReg), .ALUSrc(d2_ALUSrc), .RegDst(d2_RegDst),
        .BranchEq(d2_BranchEq), .BranchNe(d2_BranchNe), .Jump(d2_Jump),
        .ex_valid(d2_ex_valid), .illegal(d2_illegal), .illegal_cnt(d2_cnt)
    );

    always #5 clk = ~clk;

    wire [8:0] w_ctrl = {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, BranchEq, BranchNe, Jump};

    typedef struct {
        logic       ev;
        logic [1:0] aop;
        logic [5:0] fn;
        logic [8:0] ctrl;
        logic       ill;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   m_boot = 1'b1;
    int   m_cnt = 0;
    int   m_cnt2 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic compare_out(input exp_t e);
        check("ex_valid", {31'b0, ex_valid}, {31'b0, e.ev});
        check("ALUop", {30'b0, ALUop}, {30'b0, e.aop});
        check("func", {26'b0, func}, {26'b0, e.fn});
        check("ctrl", {23'b0, w_ctrl}, {23'b0, e.ctrl});
        check("illegal", {31'b0, illegal}, {31'b0, e.ill});
        check("illegal_cnt", {24'b0, illegal_cnt}, {24'b0, e.cnt});
        check("illegal_cnt_w2", {30'b0, d2_cnt}, {30'b0, e.cnt2});
    endtask

    // Reference decode: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, BranchEq, BranchNe, Jump}
    task automatic ref_decode(input logic [5:0] op, input logic [5:0] fn,
                              output bit legal, output logic [1:0] aop, output logic [8:0] ctrl);
        legal = 1'b1; aop = 2'b00; ctrl = 9'b0;
        case (op)
            OP_R: begin
                aop = 2'b10; ctrl = 9'b100001000;
                legal = (fn == F_ADD) || (fn == F_SUB) || (fn == F_SLT);
            end
            OP_LW:   ctrl = 9'b110110000;
            OP_SW:   ctrl = 9'b001010000;
            OP_ADDI: ctrl = 9'b100010000;
            OP_SLTI: begin aop = 2'b11; ctrl = 9'b100010000; end
            OP_BEQ:  begin aop = 2'b01; ctrl = 9'b000000100; end
            OP_BNE:  begin aop = 2'b01; ctrl = 9'b000000010; end
            OP_J:    ctrl = 9'b000000001;
            default: legal = 1'b0;
        endcase
    endtask

    task automatic step(input logic [5:0] op, input logic [5:0] fn,
                        input bit v, input bit st, input bit fl, input bit rel);
        exp_t e;
        bit legal;
        logic [1:0] aop;
        logic [8:0] ctrl;
        @(negedge clk);
        if (sb.size() > 0) compare_out(sb.pop_front());
        if (rel) rst = 1'b1;
        opcode = op; funct = fn; id_valid = v; stall = st; flush = fl;
        e.ev = 1'b0; e.aop = 2'b00; e.fn = 6'b0; e.ctrl = 9'b0; e.ill = 1'b0;
        ref_decode(op, fn, legal, aop, ctrl);
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (!fl && !st && v) begin
            if (legal) begin
                e.ev = 1'b1; e.aop = aop; e.ctrl = ctrl;
                e.fn = (op == OP_R) ? fn : 6'b0;
            end else begin
                e.ill = 1'b1;
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
        e.cnt = m_cnt[7:0];
        e.cnt2 = m_cnt2[1:0];
        sb.push_back(e);
    endtask

    task automatic drain();
        @(negedge clk);
        while (sb.size() > 0) compare_out(sb.pop_front());
    endtask

    task automatic async_reset_check();
        drain();
        #2 rst = 1'b0;
        #1;
        check("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("rst_ALUop", {30'b0, ALUop}, 32'd0);
        check("rst_func", {26'b0, func}, 32'd0);
        check("rst_ctrl", {23'b0, w_ctrl}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        check("rst_cnt", {24'b0, illegal_cnt}, 32'd0);
        check("rst_cnt_w2", {30'b0, d2_cnt}, 32'd0);
        m_boot = 1'b1; m_cnt = 0; m_cnt2 = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("por_ex_valid", {31'b0, ex_valid}, 32'd0);
        check("por_cnt", {24'b0, illegal_cnt}, 32'd0);

        // Release with lw applied: BOOT bubble first, then lw
        step(OP_LW, 6'd7, 1, 0, 0, 1);
        step(OP_LW, 6'd7, 1, 0, 0, 0);

        // Decode sweep
        step(OP_R, F_ADD, 1, 0, 0, 0);
        step(OP_R, F_SUB, 1, 0, 0, 0);
        step(OP_R, F_SLT, 1, 0, 0, 0);
        step(OP_SW, 6'd3, 1, 0, 0, 0);
        step(OP_ADDI, 6'd1, 1, 0, 0, 0);
        step(OP_SLTI, 6'd5, 1, 0, 0, 0);
        step(OP_BEQ, 6'd0, 1, 0, 0, 0);
        step(OP_BNE, 6'd0, 1, 0, 0, 0);
        step(OP_J, 6'd9, 1, 0, 0, 0);

        // Stall, flush, flush+stall, invalid
        step(OP_R, F_SUB, 1, 1, 0, 0);
        step(OP_R, F_SUB, 1, 1, 1, 0);
        step(OP_BAD, 6'd0, 1, 1, 1, 0);
        step(OP_BAD, 6'd0, 1, 0, 1, 0);
        step(OP_LW, 6'd0, 0, 0, 0, 0);

        // Back-to-back throughput
        step(OP_LW, 6'd0, 1, 0, 0, 0);
        step(OP_SW, 6'd0, 1, 0, 0, 0);
        step(OP_BEQ, 6'd0, 1, 0, 0, 0);
        step(OP_J, 6'd0, 1, 0, 0, 0);
        step(OP_ADDI, 6'd0, 1, 0, 0, 0);
        step(OP_LW, 6'd0, 1, 0, 0, 0);

        // Asynchronous reset mid-run while ex_valid=1
        async_reset_check();
        step(OP_LW, 6'd0, 1, 0, 0, 1);
        step(OP_LW, 6'd0, 1, 0, 0, 0);

        // Illegal detection, then a stalled illegal that must not count
        step(OP_BAD, 6'd0, 1, 0, 0, 0);
        step(OP_R, F_AND, 1, 0, 0, 0);
        step(OP_BAD, 6'd0, 1, 1, 0, 0);
        step(OP_R, F_ADD, 1, 0, 0, 0);

        // Saturation from a clean count
        async_reset_check();
        step(OP_ADDI, 6'd0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(OP_BAD, 6'(i), 1, 0, 0, 0);
        step(OP_SLTI, 6'd0, 1, 0, 0, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
